// File: rtl/jtag_cfg_driver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : jtag_cfg_driver                                           |
// | Purpose  : JTAG master; loads the config IR once after reset, then   |
// |            pushes each accepted byte LSB-first through one DR scan.  |
// | Option   : JTAG_CFG_READBACK_EN adds TDO capture (oCapDat/oCapVld)   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module jtag_cfg_driver #(
  parameter int                CLK_DIV = 2,
  parameter int                IR_LEN  = 4,
  parameter logic [IR_LEN-1:0] IR_CODE = 4'b0010
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic [7:0] iDat,
  input  logic       iValid,
  output logic       oReady,
  output logic       oBusy,
  output logic       oTck,
  output logic       oTms,
  output logic       oTdi,
  input  logic       iTdo,
  output logic [7:0] oCapDat,
  output logic       oCapVld
);

  localparam int c_phW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int c_irSeqLen = IR_LEN + 6;
  localparam int c_drSeqLen = 13;
  localparam int c_maxSeq   = (c_irSeqLen > c_drSeqLen) ? c_irSeqLen : c_drSeqLen;
  localparam int c_cntW     = $clog2(c_maxSeq + 1);
  localparam int c_shW      = (IR_LEN > 8) ? IR_LEN : 8;
  localparam logic [c_phW-1:0] c_phMax = c_phW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    T_RESET = 3'd0,
    T_RTI   = 3'd1,
    IR_LOAD = 3'd2,
    READY   = 3'd3,
    DR_SCAN = 3'd4
  } state_t;

  state_t             r_state;
  logic [c_cntW-1:0]  r_cnt;     // TCK rises completed in the current state
  logic [c_phW-1:0]   r_phase;
  logic [c_shW-1:0]   r_shift;

  state_t             w_nxtState;
  logic [c_cntW-1:0]  w_nxtCnt;
  logic               w_nxtTms;
  logic               w_nxtTdi;
  logic               w_run;
  logic               w_tick;
  logic               w_rise;
  logic               w_fall;

  function automatic int seqLen(input state_t s);
    case (s)
      T_RESET: return 5;
      T_RTI:   return 1;
      IR_LOAD: return c_irSeqLen;
      DR_SCAN: return c_drSeqLen;
      default: return 0;
    endcase
  endfunction

  function automatic logic isShift(input state_t s, input int n);
    case (s)
      IR_LOAD: return (n >= 4) && (n < 4 + IR_LEN);
      DR_SCAN: return (n >= 3) && (n < 11);
      default: return 1'b0;
    endcase
  endfunction

  // READY parks TMS high so the next scan starts with Select-DR already set up.
  function automatic logic tmsFor(input state_t s, input int n);
    case (s)
      T_RTI:   return 1'b0;
      IR_LOAD: return (n < 2) || (n == 3 + IR_LEN) || (n == 4 + IR_LEN);
      DR_SCAN: return (n == 0) || (n == 10) || (n == 11);
      default: return 1'b1;
    endcase
  endfunction

  assign w_run  = (r_state != READY);
  assign w_tick = w_run && (r_phase == c_phMax);
  assign w_rise = w_tick && !oTck;
  assign w_fall = w_tick && oTck;

  always_comb begin
    w_nxtState = r_state;
    w_nxtCnt   = r_cnt;
    if (int'(r_cnt) == seqLen(r_state)) begin
      w_nxtCnt = '0;
      case (r_state)
        T_RESET: w_nxtState = T_RTI;
        T_RTI:   w_nxtState = IR_LOAD;
        default: w_nxtState = READY;
      endcase
    end
    w_nxtTms = tmsFor(w_nxtState, int'(w_nxtCnt));
    w_nxtTdi = isShift(w_nxtState, int'(w_nxtCnt)) ? r_shift[0] : 1'b0;
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state <= T_RESET;
      r_cnt   <= '0;
      r_phase <= '0;
      r_shift <= c_shW'(IR_CODE);
      oTck    <= 1'b0;
      oTms    <= 1'b1;
      oTdi    <= 1'b0;
      oReady  <= 1'b0;
      oBusy   <= 1'b1;
    end else if (!w_run) begin
      if (iValid && oReady) begin
        r_state <= DR_SCAN;
        r_cnt   <= '0;
        r_shift <= c_shW'(iDat);
        oReady  <= 1'b0;
        oBusy   <= 1'b1;
      end
    end else begin
      r_phase <= w_tick ? '0 : r_phase + c_phW'(1);
      if (w_tick) oTck <= !oTck;
      if (w_rise) begin
        r_cnt <= r_cnt + c_cntW'(1);
        if (isShift(r_state, int'(r_cnt))) r_shift <= r_shift >> 1;
      end
      // All TMS/TDI changes and state transitions happen on the TCK fall.
      if (w_fall) begin
        r_state <= w_nxtState;
        r_cnt   <= w_nxtCnt;
        oTms    <= w_nxtTms;
        oTdi    <= w_nxtTdi;
        if (w_nxtState == READY) begin
          oReady <= 1'b1;
          oBusy  <= 1'b0;
        end
      end
    end
  end

`ifdef JTAG_CFG_READBACK_EN
  always_ff @(posedge iClk) begin
    if (iRst) begin
      oCapDat <= '0;
      oCapVld <= 1'b0;
    end else begin
      oCapVld <= w_rise && (r_state == DR_SCAN) && (int'(r_cnt) == 11);
      if (w_rise && (r_state == DR_SCAN) && isShift(r_state, int'(r_cnt)))
        oCapDat <= {iTdo, oCapDat[7:1]};
    end
  end
`else
  logic w_unusedTdo;
  assign w_unusedTdo = iTdo;
  assign oCapDat     = '0;
  assign oCapVld     = 1'b0;
`endif

endmodule
`default_nettype wire
